// File: rtl/dispatch_serialize_ctrl_pkg.sv
// dispatch_serialize_ctrl_pkg: shared decode/dispatch types and helpers
package dispatch_serialize_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, WAIT} serial_state_t;
  typedef struct packed {
    logic valid;
    logic is_sp;
    logic is_priv;
    logic is_eret;
  } decoded_inst_t;
  function automatic logic [1:0] pop2(input logic [1:0] x);
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction
endpackage

// File: rtl/dispatch_serialize_ctrl.sv
// dispatch_serialize_ctrl: serializes special ops between decode and dispatch
module dispatch_serialize_ctrl
  import dispatch_serialize_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [1:0]       in_is_sp,
  input  logic [1:0]       in_is_priv,
  input  logic [1:0]       in_is_eret,
  input  logic             ds_ready,
  input  logic             rob_empty,
  input  logic             sb_empty,
  input  logic             sp_done,
  output logic [1:0]       out_valid,
  output logic [1:0]       consume,
  output logic             dec_stall,
  output logic             fetch_hold,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  serial_state_t state, state_n;
  logic cur_priv, cur_eret, priv_n, eret_n, drain_ok;
  logic [1:0] v;
  logic unused_slot1;
  assign unused_slot1 = ^{in_is_priv[1], in_is_eret[1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_priv  <= 1'b0;
      cur_eret  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      cur_priv  <= priv_n;
      cur_eret  <= eret_n;
      stall_cnt <= (state != IDLE) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
  always_comb begin
    v         = {in_valid == 2'b11, in_valid[0]};
    drain_ok  = rob_empty && (sb_empty || !cur_priv);
    out_valid = 2'b00;
    state_n   = state;
    priv_n    = cur_priv;
    eret_n    = cur_eret;
    case (state)
      IDLE:
        if (v[0] && in_is_sp[0]) begin
          state_n = DRAIN;
          priv_n  = in_is_priv[0];
          eret_n  = in_is_eret[0];
        end else begin
          out_valid = (v[1] && in_is_sp[1]) ? {1'b0, ds_ready} : v & {2{ds_ready}};
        end
      DRAIN:
        if (drain_ok && ds_ready) begin
          out_valid = 2'b01;
          state_n   = WAIT;
        end
      WAIT:
        if (sp_done) begin
          state_n = IDLE;
          priv_n  = 1'b0;
          eret_n  = 1'b0;
        end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      out_valid = 2'b00;
      state_n   = IDLE;
      priv_n    = 1'b0;
      eret_n    = 1'b0;
    end
    consume   = pop2(out_valid);
    dec_stall = consume != pop2(v);
  end
  assign busy       = state != IDLE;
  assign fetch_hold = (state == WAIT) && (cur_eret || cur_priv);
endmodule

// File: tb/tb_dispatch_serialize_ctrl.sv
// tb_dispatch_serialize_ctrl: scoreboard bench for dispatch_serialize_ctrl
module tb_dispatch_serialize_ctrl;
  logic clk = 1'b0, rst, flush, ds_ready, rob_empty, sb_empty, sp_done;
  logic [1:0] in_valid, in_is_sp, in_is_priv, in_is_eret, out_valid, consume;
  logic dec_stall, fetch_hold, busy;
  logic [31:0] stall_cnt;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic [1:0] ov;
    logic [1:0] cn;
    logic       ds;
    logic       bz;
    logic       fh;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  dispatch_serialize_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_is_sp(in_is_sp),
    .in_is_priv(in_is_priv), .in_is_eret(in_is_eret), .ds_ready(ds_ready),
    .rob_empty(rob_empty), .sb_empty(sb_empty), .sp_done(sp_done),
    .out_valid(out_valid), .consume(consume), .dec_stall(dec_stall),
    .fetch_hold(fetch_hold), .busy(busy), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [1:0] v, sp, pr, er,
                     input logic rdy, re, se, dn, fl,
                     input logic [1:0] eov, ecn, input logic eds, ebz, efh);
    exp_t e;
    in_valid = v; in_is_sp = sp; in_is_priv = pr; in_is_eret = er;
    ds_ready = rdy; rob_empty = re; sb_empty = se; sp_done = dn; flush = fl;
    q.push_back('{eov, ecn, eds, ebz, efh});
    @(negedge clk);
    e = q.pop_front();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    chk({tag, ".consume"}, 32'(consume), 32'(e.cn));
    chk({tag, ".dec_stall"}, 32'(dec_stall), 32'(e.ds));
    chk({tag, ".busy"}, 32'(busy), 32'(e.bz));
    chk({tag, ".fetch_hold"}, 32'(fetch_hold), 32'(e.fh));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; in_is_sp = 2'b00; in_is_priv = 2'b00;
    in_is_eret = 2'b00; ds_ready = 1'b1; rob_empty = 1'b1; sb_empty = 1'b1; sp_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.fetch_hold", 32'(fetch_hold), 0);
    chk("reset.stall_cnt", stall_cnt, 0);
    chk("reset.out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc("pair", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b11, 2'd2, 0, 0, 0);
    cyc("pair_nrdy", 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'd0, 1, 0, 0);
    cyc("illegal10", 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'd0, 0, 0, 0);
    cyc("sp_slot1", 2'b11, 2'b10, 2'b00, 2'b00, 1, 1, 1, 1, 0, 2'b01, 2'd1, 1, 0, 0);
    cyc("mtc0_t", 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'd0, 1, 0, 0);
    repeat (3) cyc("mtc0_drain", 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'd0, 1, 1, 0);
    cyc("mtc0_disp", 2'b01, 2'b01, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b01, 2'd1, 0, 1, 0);
    repeat (4) cyc("mtc0_wait", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'd0, 0, 1, 0);
    cyc("mtc0_done", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 1, 0, 2'b00, 2'd0, 0, 1, 0);
    chk("mtc0.stall_cnt", stall_cnt, 9);
    cyc("after_sp", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b11, 2'd2, 0, 0, 0);
    cyc("cache_t", 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'd0, 1, 0, 0);
    repeat (2) cyc("cache_sb", 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'd0, 1, 1, 0);
    cyc("cache_nrdy", 2'b01, 2'b01, 2'b01, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'd0, 1, 1, 0);
    cyc("cache_disp", 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 1, 0, 0, 2'b01, 2'd1, 0, 1, 0);
    repeat (2) cyc("cache_wait", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'd0, 0, 1, 1);
    cyc("cache_done", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 1, 0, 2'b00, 2'd0, 0, 1, 1);
    chk("cache.stall_cnt", stall_cnt, 16);
    cyc("cache_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'd0, 0, 0, 0);
    cyc("eret_t", 2'b01, 2'b01, 2'b00, 2'b01, 1, 1, 1, 0, 0, 2'b00, 2'd0, 1, 0, 0);
    cyc("eret_disp", 2'b01, 2'b01, 2'b00, 2'b01, 1, 1, 1, 0, 0, 2'b01, 2'd1, 0, 1, 0);
    cyc("eret_wait", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'd0, 0, 1, 1);
    cyc("eret_flush", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 1, 1, 2'b00, 2'd0, 1, 1, 1);
    cyc("post_flush", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b11, 2'd2, 0, 0, 0);
    cyc("fd_t", 2'b01, 2'b01, 2'b01, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'd0, 1, 0, 0);
    cyc("fd_flush", 2'b01, 2'b01, 2'b01, 2'b00, 1, 1, 1, 0, 1, 2'b00, 2'd0, 1, 1, 0);
    cyc("fd_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'd0, 0, 0, 0);
    cyc("rd_t", 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'd0, 1, 0, 0);
    cyc("rd_drain", 2'b01, 2'b01, 2'b00, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'd0, 1, 1, 0);
    in_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", 32'(busy), 0);
    chk("rst_mid.stall_cnt", stall_cnt, 0);
    chk("rst_mid.out_valid", 32'(out_valid), 0);
    chk("rst_mid.consume", 32'(consume), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc("post_rst", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 1, 0, 0, 2'b11, 2'd2, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
